// File: rtl/y86_pkg.sv
// Shared Y86 definitions: word width, icodes, status codes, data-memory FSM states
// and the data-memory address legality check.
package y86_pkg;
  localparam int WORD_W = 64;

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Full 61-bit index compare so huge addresses cannot alias into range.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int words);
    return (addr[2:0] != 3'd0) || (addr[WORD_W-1:3] >= 61'(words));
  endfunction
endpackage

// File: rtl/y86_dmem_array.sv
// Word-addressed 64-bit storage with a registered read. A read issued in the same
// cycle as a write to the same word returns the new data.
module y86_dmem_array #(
  parameter int WORDS = 1024,
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic          rd_en,
  input  logic          rd_zero,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);
  logic [63:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds between reads; rd_zero loads 0 for writes and errors.
  always_ff @(posedge clk) begin
    if (reset)
      rdata <= '0;
    else if (rd_en) begin
      if (rd_zero)                  rdata <= '0;
      else if (we && waddr == raddr) rdata <= wdata;
      else                          rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/y86_dmem_responder.sv
// Y86 memory-stage data responder: one request at a time over valid/ready,
// response after LATENCY cycles, mem_busy for pipeline stall control.
module y86_dmem_responder
  import y86_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_busy
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_t   state;
  logic [3:0]    cnt;
  logic          cap_write, cap_err;
  logic [AW-1:0] cap_idx;
  logic [63:0]   cap_wdata;

  logic          accept, req_err, we;
  logic [AW-1:0] req_idx;
  logic          issue, iss_zero, iss_err;
  logic [AW-1:0] iss_idx;

  assign accept   = req_valid & req_ready;
  assign req_err  = addr_err(req_addr, MEM_WORDS);
  assign req_idx  = req_addr[AW+2:3];
  assign mem_busy = ~req_ready;

  // Storage read is issued one cycle ahead of RESP so data lands with rsp_valid.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign issue    = accept;
      assign iss_err  = req_err;
      assign iss_zero = req_write | req_err;
      assign iss_idx  = req_idx;
    end else begin : g_latn
      assign issue    = (state == WAIT) && (cnt == 4'd1);
      assign iss_err  = cap_err;
      assign iss_zero = cap_write | cap_err;
      assign iss_idx  = cap_idx;
    end
  endgenerate

  // Write commits on the edge that ends RESP; reset drops it.
  assign we = (state == RESP) && cap_write && !cap_err && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (issue) rsp_error <= iss_err;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            cap_write <= req_write;
            cap_err   <= req_err;
            cap_idx   <= req_idx;
            cap_wdata <= req_wdata;
            cnt       <= CNT_INIT;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              req_ready <= 1'b1;
            end else begin
              state     <= WAIT;
              req_ready <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  y86_dmem_array #(.WORDS(MEM_WORDS)) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (cap_idx),
    .wdata   (cap_wdata),
    .rd_en   (issue),
    .rd_zero (iss_zero),
    .raddr   (iss_idx),
    .rdata   (rsp_rdata)
  );
endmodule

// File: tb/tb_y86_dmem_responder.sv
// Bench for y86_dmem_responder: directed table, multi-cycle corner sequences,
// randomized traffic against a word-array model, and a LATENCY=1 instance.
module tb_y86_dmem_responder;
  localparam int LAT   = 2;
  localparam int WORDS = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v, w, rdy, rv, re, busy;
  logic [63:0] a, d, rd;
  logic        v1, w1, rdy1, rv1, re1, busy1;
  logic [63:0] a1, d1, rd1;

  y86_dmem_responder #(.MEM_WORDS(WORDS), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(v), .req_ready(rdy), .req_write(w),
    .req_addr(a), .req_wdata(d), .rsp_valid(rv), .rsp_rdata(rd),
    .rsp_error(re), .mem_busy(busy));

  y86_dmem_responder #(.MEM_WORDS(WORDS), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
    .req_addr(a1), .req_wdata(d1), .rsp_valid(rv1), .rsp_rdata(rd1),
    .rsp_error(re1), .mem_busy(busy1));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference memory: plain word array plus a written flag (storage is never cleared).
  logic [63:0] mdl [WORDS];
  bit          known [WORDS];

  function automatic bit m_err(input logic [63:0] ad);
    return (ad % 8 != 0) || (ad / 8 >= 64'(WORDS));
  endfunction

  task automatic xact(input string nm, input logic wr, input logic [63:0] ad,
                      input logic [63:0] dt, output logic [63:0] grd, output logic gerr);
    int lat, idx;
    bit e;
    e = m_err(ad);
    @(negedge clk);
    v = 1'b1; w = wr; a = ad; d = dt;
    lat = 0;
    while (!rdy && lat < 20) begin @(negedge clk); lat++; end
    if (!rdy) chk({nm, " ready"}, 64'(rdy), 64'd1);
    @(posedge clk); #1 v = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (rv) break;
    end
    chk({nm, " latency"}, 64'(lat), 64'(LAT));
    grd = rd; gerr = re;
    chk({nm, " error"}, 64'(re), 64'(e));
    if (e || wr) chk({nm, " rdata"}, rd, 64'd0);
    else begin
      idx = int'(ad / 8);
      if (known[idx]) chk({nm, " rdata"}, rd, mdl[idx]);
    end
    if (wr && !e) begin
      idx = int'(ad / 8);
      mdl[idx] = dt; known[idx] = 1'b1;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [63:0] ad;
    logic [63:0] dt;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] grd, ad, dt, D3;
    logic        gerr, wr;
    logic [63:0] d1s [4];
    logic [63:0] e1 [8];
    int          k;

    reset = 1'b1;
    v = 0; w = 0; a = '0; d = '0;
    v1 = 0; w1 = 0; a1 = '0; d1 = '0;
    for (int i = 0; i < WORDS; i++) known[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 64'(rdy), 64'd1);
    chk("reset mem_busy", 64'(busy), 64'd0);
    chk("reset rsp_valid", 64'(rv), 64'd0);
    chk("reset rsp_rdata", rd, 64'd0);
    chk("reset rsp_error", 64'(re), 64'd0);
    chk("reset lat1 req_ready", 64'(rdy1), 64'd1);
    reset = 1'b0;

    // Directed table: basic write/read, misaligned, out of range, last word, wrap.
    tbl[0] = '{1'b1, 64'h40,   64'h1122334455667788, 64'h0, 1'b0};
    tbl[1] = '{1'b0, 64'h40,   64'h0, 64'h1122334455667788, 1'b0};
    tbl[2] = '{1'b0, 64'h43,   64'h0, 64'h0, 1'b1};
    tbl[3] = '{1'b0, 64'h2000, 64'h0, 64'h0, 1'b1};
    tbl[4] = '{1'b1, 64'h44,   64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1};
    tbl[5] = '{1'b0, 64'h40,   64'h0, 64'h1122334455667788, 1'b0};
    tbl[6] = '{1'b1, 64'h1FF8, 64'hCAFE_F00D_0BAD_BEEF, 64'h0, 1'b0};
    tbl[7] = '{1'b0, 64'h1FF8, 64'h0, 64'hCAFE_F00D_0BAD_BEEF, 1'b0};
    tbl[8] = '{1'b0, 64'h8000_0000_0000_0040, 64'h0, 64'h0, 1'b1};
    tbl[9] = '{1'b1, 64'h2000, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      xact($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].ad, tbl[i].dt, grd, gerr);
      chk($sformatf("tbl%0d exp_rdata", i), grd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d exp_error", i), 64'(gerr), 64'(tbl[i].exp_err));
    end

    // Back-to-back: write @0x10 accepted in the RESP cycle of a read @0x40.
    D3 = 64'hA5A5_0000_1234_5678;
    @(negedge clk); v = 1; w = 0; a = 64'h40;
    @(posedge clk); #1 w = 1; a = 64'h10; d = D3;
    @(negedge clk);
    chk("b2b wait busy", 64'(busy), 64'd1);
    chk("b2b wait rsp_valid", 64'(rv), 64'd0);
    @(negedge clk);
    chk("b2b read rsp_valid", 64'(rv), 64'd1);
    chk("b2b read rdata", rd, 64'h1122334455667788);
    chk("b2b read ready", 64'(rdy), 64'd1);
    @(posedge clk); #1 v = 0;
    @(negedge clk);
    chk("b2b write busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("b2b write rsp_valid", 64'(rv), 64'd1);
    chk("b2b write rdata", rd, 64'd0);
    mdl[2] = D3; known[2] = 1'b1;
    xact("b2b readback", 1'b0, 64'h10, 64'h0, grd, gerr);
    chk("b2b readback data", grd, D3);

    // Address changes during WAIT are ignored.
    @(negedge clk); v = 1; w = 0; a = 64'h40;
    @(posedge clk); #1 a = 64'h10;
    @(negedge clk);
    chk("hold busy", 64'(busy), 64'd1);
    chk("hold rsp_valid", 64'(rv), 64'd0);
    a = 64'h18;
    @(negedge clk);
    chk("hold rsp_valid resp", 64'(rv), 64'd1);
    chk("hold rdata", rd, 64'h1122334455667788);
    v = 0;
    @(negedge clk);
    chk("hold pulse end", 64'(rv), 64'd0);
    chk("hold idle ready", 64'(rdy), 64'd1);

    // Reset during WAIT of a write drops it.
    xact("rst prewrite", 1'b1, 64'h80, 64'h5555, grd, gerr);
    @(negedge clk); v = 1; w = 1; a = 64'h80; d = 64'hDEAD;
    @(posedge clk); #1 v = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rst rsp_valid", 64'(rv), 64'd0);
    chk("rst req_ready", 64'(rdy), 64'd1);
    chk("rst mem_busy", 64'(busy), 64'd0);
    chk("rst rsp_error", 64'(re), 64'd0);
    reset = 1'b0;
    @(negedge clk); chk("rst no late rsp", 64'(rv), 64'd0);
    @(negedge clk); chk("rst no late rsp2", 64'(rv), 64'd0);
    xact("rst readback", 1'b0, 64'h80, 64'h0, grd, gerr);
    chk("rst readback data", grd, 64'h5555);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 15));
      ad = 64'h100 + 64'(k) * 8;
      if ($urandom_range(0, 7) == 0) ad = ad + 64'($urandom_range(1, 7));
      if ($urandom_range(0, 15) == 0) ad = {$urandom, $urandom} | 64'h1_0000_0000;
      if ($urandom_range(0, 15) == 0) ad = 64'h2000 + 64'($urandom_range(0, 31)) * 8;
      wr = 1'($urandom_range(0, 1));
      dt = {$urandom, $urandom};
      xact($sformatf("rnd%0d", i), wr, ad, dt, grd, gerr);
    end

    // LATENCY=1 instance: four writes then four reads, all back-to-back.
    for (int i = 0; i < 4; i++) begin
      d1s[i] = {$urandom, $urandom};
      e1[i] = 64'd0;
      e1[i+4] = d1s[i];
    end
    @(negedge clk);
    chk("lat1 idle ready", 64'(rdy1), 64'd1);
    v1 = 1; w1 = 1; a1 = 64'h200; d1 = d1s[0];
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 7) begin
        w1 = (i + 1 < 4);
        a1 = 64'h200 + 64'((i + 1) % 4) * 8;
        d1 = d1s[(i + 1) % 4];
      end else v1 = 0;
      @(negedge clk);
      chk($sformatf("lat1 op%0d rsp_valid", i), 64'(rv1), 64'd1);
      chk($sformatf("lat1 op%0d ready", i), 64'(rdy1), 64'd1);
      chk($sformatf("lat1 op%0d rdata", i), rd1, e1[i]);
      chk($sformatf("lat1 op%0d error", i), 64'(re1), 64'd0);
    end
    @(negedge clk);
    chk("lat1 pulse end", 64'(rv1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
